// File: rtl/digit_display_ctrl.sv
// Decimal readout sequencer: binary -> BCD by double-dabble, frame-synced commit, per-pixel digit slot decode.
// Ports: clk, rst_n (sync, active-low), value/load/busy/overflow, frame_start, x_cnt/y_cnt, base_x/base_y,
//        number (15 = blank), x_pin/y_pin, x_width/y_width. Optional macro: LEADING_ZERO_BLANK_EN.
module digit_display_ctrl #(
  parameter int NUM_DIGITS = 3,
  parameter int VAL_W      = 10,
  parameter int DIGIT_W    = 30,
  parameter int DIGIT_H    = 45,
  parameter int GAP        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VAL_W-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             overflow,
  input  logic             frame_start,
  input  logic [9:0]       x_cnt,
  input  logic [9:0]       y_cnt,
  input  logic [9:0]       base_x,
  input  logic [9:0]       base_y,
  output logic [3:0]       number,
  output logic [9:0]       x_pin,
  output logic [9:0]       y_pin,
  output logic [9:0]       x_width,
  output logic [9:0]       y_width
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(VAL_W + 1);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int         MAX_VAL = pow10(NUM_DIGITS) - 1;
  localparam logic [9:0] PITCH   = 10'(DIGIT_W + GAP);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state;
  logic [VAL_W-1:0]  bin;
  logic [BW-1:0]     bcd;
  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     shadow;
  logic [BW-1:0]     disp;
  logic [CW-1:0]     iter;
  logic              sat;
  logic              shadow_ovf;
  logic              pending;
  logic [NUM_DIGITS-1:0] blank;
  logic [9:0]        lo;

  // y_cnt is part of the pixel bus but only x selects a slot
  logic unused_y;
  assign unused_y = ^y_cnt;

  assign x_width = 10'(DIGIT_W);
  assign y_width = 10'(DIGIT_H);

  // double-dabble correction before each shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bin        <= '0;
      bcd        <= '0;
      iter       <= '0;
      sat        <= 1'b0;
      shadow     <= '0;
      shadow_ovf <= 1'b0;
      pending    <= 1'b0;
      disp       <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // commit first so a DONE in the same cycle re-arms pending
      if (frame_start && pending) begin
        disp     <= shadow;
        overflow <= shadow_ovf;
        pending  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (load) begin
            bin   <= value;
            bcd   <= '0;
            sat   <= 32'(value) > 32'(MAX_VAL);
            iter  <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          bcd <= {bcd_adj[BW-2:0], bin[VAL_W-1]};
          bin <= bin << 1;
          if (iter == CW'(VAL_W - 1))
            state <= DONE;
          else
            iter <= iter + 1'b1;
        end
        DONE: begin
          shadow     <= sat ? {NUM_DIGITS{4'h9}} : bcd;
          shadow_ovf <= sat;
          pending    <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  // zeros left of the first nonzero digit go blank; last digit always shown
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int k = 0; k < NUM_DIGITS - 1; k++) begin
      if (lead && disp[4*(NUM_DIGITS-1-k) +: 4] == 4'd0)
        blank[k] = 1'b1;
      else
        lead = 1'b0;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    number = 4'hF;
    x_pin  = base_x;
    y_pin  = base_y;
    lo     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lo = base_x + 10'(k * (DIGIT_W + GAP));
      if (x_cnt >= lo && x_cnt < lo + PITCH) begin
        x_pin  = lo;
        number = blank[k] ? 4'hF : disp[4*(NUM_DIGITS-1-k) +: 4];
      end
    end
  end

endmodule

// File: tb/tb_digit_display_ctrl.sv
// Self-checking bench for digit_display_ctrl: table of pixel probes, hand sequences, random loads vs a decimal model.
// Honors LEADING_ZERO_BLANK_EN in its expectations.
module tb_digit_display_ctrl;

  localparam int ND    = 3;
  localparam int BX    = 100;
  localparam int BY    = 50;
  localparam int PITCH = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] value;
  logic       load;
  logic       busy;
  logic       overflow;
  logic       frame_start;
  logic [9:0] x_cnt, y_cnt, base_x, base_y;
  logic [3:0] number;
  logic [9:0] x_pin, y_pin, x_width, y_width;

  digit_display_ctrl dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy), .overflow(overflow), .frame_start(frame_start),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .base_x(base_x), .base_y(base_y),
    .number(number), .x_pin(x_pin), .y_pin(y_pin),
    .x_width(x_width), .y_width(y_width)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // model: values as plain integers
  int disp_m   = 0;
  int dovf_m   = 0;
  int shadow_m = 0;
  int sovf_m   = 0;
  int pend_m   = 0;

  typedef struct {
    int x;
    int xpin;
    int slot;
  } probe_t;

  probe_t probes[6];

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_num(input int v, input int k);
    int p;
    p = 1;
    for (int i = 0; i < ND - 1 - k; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (k < ND - 1 && v < p) return 15;
`endif
    return (v / p) % 10;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    value = 10'(v);
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_idle(input int v);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("busy_timeout", int'(busy), 0);
    shadow_m = v > 999 ? 999 : v;
    sovf_m   = v > 999 ? 1 : 0;
    pend_m   = 1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (pend_m != 0) begin
      disp_m = shadow_m;
      dovf_m = sovf_m;
      pend_m = 0;
    end
  endtask

  task automatic check_disp(input string tag);
    for (int k = 0; k < ND; k++) begin
      x_cnt = 10'(BX + k * PITCH + 5);
      #1;
      chk({tag, "_num"}, int'(number), exp_num(disp_m, k));
      chk({tag, "_xpin"}, int'(x_pin), BX + k * PITCH);
    end
    chk({tag, "_ypin"}, int'(y_pin), BY);
    chk({tag, "_ovf"}, int'(overflow), dovf_m);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, v, x, k;
    probes[0] = '{131, 100, 0};
    probes[1] = '{132, 132, 1};
    probes[2] = '{196, 100, -1};
    probes[3] = '{99, 100, -1};
    probes[4] = '{100, 100, 0};
    probes[5] = '{195, 164, 2};

    rst_n = 1'b0; value = '0; load = 1'b0; frame_start = 1'b0;
    x_cnt = '0; y_cnt = 10'd60; base_x = 10'(BX); base_y = 10'(BY);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    chk("rst_busy", int'(busy), 0);
    chk("x_width", int'(x_width), 30);
    chk("y_width", int'(y_width), 45);
    check_disp("rst");

    // 437: busy length, no change before frame, then commit
    do_load(437);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("busy_cycles", cnt, 11);
    shadow_m = 437; sovf_m = 0; pend_m = 1;
    check_disp("pre_frame");
    frame();
    check_disp("v437");

    // pixel probe table
    for (int i = 0; i < 6; i++) begin
      x_cnt = 10'(probes[i].x);
      #1;
      chk("probe_xpin", int'(x_pin), probes[i].xpin);
      chk("probe_num", int'(number),
          probes[i].slot < 0 ? 15 : exp_num(disp_m, probes[i].slot));
    end

    // 1023 saturates; load 12 together with the commit frame
    do_load(1023);
    wait_idle(1023);
    value = 10'd12; load = 1'b1; frame_start = 1'b1;
    tick();
    load = 1'b0; frame_start = 1'b0;
    disp_m = shadow_m; dovf_m = sovf_m; pend_m = 0;
    chk("load_with_frame_busy", int'(busy), 1);
    check_disp("v1023");
    wait_idle(12);
    frame();
    check_disp("v12");

    // load while busy is dropped
    do_load(250);
    tick(); tick();
    do_load(88);
    wait_idle(250);
    frame();
    check_disp("v250");

    // latest of two conversions wins
    do_load(123);
    wait_idle(123);
    do_load(456);
    wait_idle(456);
    frame();
    check_disp("v456");
    frame();
    check_disp("idle_frame");

    // reset mid-conversion
    do_load(999);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    disp_m = 0; dovf_m = 0; shadow_m = 0; sovf_m = 0; pend_m = 0;
    chk("rst_mid_busy", int'(busy), 0);
    tick(); tick(); tick();
    chk("rst_mid_busy2", int'(busy), 0);
    frame();
    check_disp("rst_mid");

    // random loads and pixel probes
    for (int r = 0; r < 25; r++) begin
      v = int'($urandom_range(0, 1023));
      do_load(v);
      wait_idle(v);
      if ($urandom_range(0, 3) != 0) frame();
      check_disp("rnd");
      x = int'($urandom_range(0, 300));
      x_cnt = 10'(x);
      #1;
      if (x >= BX && x < BX + ND * PITCH) begin
        k = (x - BX) / PITCH;
        chk("rnd_xpin", int'(x_pin), BX + k * PITCH);
        chk("rnd_num", int'(number), exp_num(disp_m, k));
      end else begin
        chk("rnd_xpin_out", int'(x_pin), BX);
        chk("rnd_num_out", int'(number), 15);
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
